// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl: produces the duty-cycle word for the servo PWM generator.
// It accepts a target duty cycle and clamps it to the legal servo range. On each
// PWM frame boundary it moves the live duty cycle toward the target by at most
// MAX_STEP. Once the target is reached it holds for SETTLE_FRAMES frames and then
// pulses done.
module servo_slew_ctrl #(
  parameter int DC_MIN        = 100000,
  parameter int DC_MAX        = 200000,
  parameter int DC_INIT       = 150000,
  parameter int MAX_STEP      = 2000,
  parameter int SETTLE_FRAMES = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_in,
  input  logic        target_valid_in,
  input  logic [20:0] target_dc_in,
  output logic        target_ready_out,
  output logic [20:0] dc_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        at_limit_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int CNT_W = (SETTLE_FRAMES < 2) ? 1 : $clog2(SETTLE_FRAMES + 1);

  localparam logic [20:0]      DC_MIN_W    = 21'(DC_MIN);
  localparam logic [20:0]      DC_MAX_W    = 21'(DC_MAX);
  localparam logic [20:0]      DC_INIT_W   = 21'(DC_INIT);
  localparam logic [20:0]      STEP_W      = 21'(MAX_STEP);
  localparam logic [21:0]      STEP_MAG    = 22'(MAX_STEP);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);

  state_t           state_q, state_d;
  logic [20:0]      dc_q, dc_d;
  logic [20:0]      tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             limit_q, limit_d;
  logic             done_q, done_d;

  logic             accept;
  logic [20:0]      tgt_clamped;
  logic             clamp_hit;
  logic [21:0]      diff;
  logic             diff_neg;
  logic [21:0]      diff_mag;

  assign target_ready_out = (state_q != MOVING);
  assign busy_out         = (state_q != IDLE);
  assign dc_out           = dc_q;
  assign done_out         = done_q;
  assign at_limit_out     = limit_q;
  assign accept           = target_valid_in & target_ready_out;

  // Clamp the requested duty to the legal range and flag whether clamping changed it.
  always_comb begin
    tgt_clamped = target_dc_in;
    clamp_hit   = 1'b0;
    if (target_dc_in < DC_MIN_W) begin
      tgt_clamped = DC_MIN_W;
      clamp_hit   = 1'b1;
    end else if (target_dc_in > DC_MAX_W) begin
      tgt_clamped = DC_MAX_W;
      clamp_hit   = 1'b1;
    end
  end

  // Compute the signed distance to the target and its magnitude. Both operands are
  // zero-extended to 22 bits, so bit 21 of the difference is the sign.
  always_comb begin
    diff     = {1'b0, tgt_q} - {1'b0, dc_q};
    diff_neg = diff[21];
    diff_mag = diff_neg ? (~diff + 22'd1) : diff;
  end

  // Next-state and next-datapath logic. An accepted target takes priority over a
  // frame pulse that arrives in the same cycle.
  always_comb begin
    // NOTE: every output is given a default before the case statement. This way
    // no path leaves a signal unassigned, so no latch can be inferred.
    state_d = state_q;
    dc_d    = dc_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = tgt_clamped;
          limit_d = clamp_hit;
          cnt_d   = '0;
          state_d = MOVING;
        end
      end
      MOVING: begin
        if (frame_in) begin
          if (diff_mag <= STEP_MAG) begin
            dc_d    = tgt_q;
            cnt_d   = '0;
            state_d = SETTLE;
          end else if (diff_neg) begin
            dc_d = dc_q - STEP_W;
          end else begin
            dc_d = dc_q + STEP_W;
          end
        end
      end
      SETTLE: begin
        if (accept) begin
          tgt_d   = tgt_clamped;
          limit_d = clamp_hit;
          cnt_d   = '0;
          state_d = MOVING;
        end else if (frame_in) begin
          if (cnt_q == SETTLE_LAST) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together from values sampled at the same edge.
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: duty, target, settle count, clamp flag and done pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dc_q    <= DC_INIT_W;
      tgt_q   <= DC_INIT_W;
      cnt_q   <= '0;
      limit_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      dc_q    <= dc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Testbench for servo_slew_ctrl. The expected duty word is queued whenever a frame
// pulse is driven, then popped and compared once the registered output is valid.
module tb_servo_slew_ctrl;

  localparam int GAP = 20;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        frame_in = 1'b0;
  logic        target_valid_in = 1'b0;
  logic [20:0] target_dc_in = '0;
  logic        target_ready_out;
  logic [20:0] dc_out;
  logic        busy_out;
  logic        done_out;
  logic        at_limit_out;

  int          n_checks = 0;
  int          n_fail = 0;
  int          done_seen = 0;
  int unsigned exp_q[$];

  always #5 clk_in = ~clk_in;

  servo_slew_ctrl dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .frame_in         (frame_in),
    .target_valid_in  (target_valid_in),
    .target_dc_in     (target_dc_in),
    .target_ready_out (target_ready_out),
    .dc_out           (dc_out),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .at_limit_out     (at_limit_out)
  );

  // Count every cycle in which done is high.
  always @(negedge clk_in) if (done_out) done_seen++;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic accept(input int unsigned val, input string tag);
    check({tag, "_ready"}, 32'(target_ready_out), 1);
    target_valid_in = 1'b1;
    target_dc_in    = 21'(val);
    tick();
    target_valid_in = 1'b0;
  endtask

  // Queue the expected duty, pulse frame for one cycle, then pop and compare.
  task automatic frame_expect(input int unsigned exp_dc, input string tag);
    int unsigned e;
    exp_q.push_back(exp_dc);
    frame_in = 1'b1;
    tick();
    frame_in = 1'b0;
    e = exp_q.pop_front();
    check(tag, 32'(dc_out), e);
  endtask

  initial begin
    int base;

    // T1: reset state, and a frame pulse in IDLE leaves the duty alone
    idle(2);
    do_reset();
    check("t1_dc", 32'(dc_out), 150000);
    check("t1_ready", 32'(target_ready_out), 1);
    check("t1_busy", 32'(busy_out), 0);
    check("t1_done", 32'(done_out), 0);
    check("t1_limit", 32'(at_limit_out), 0);
    idle(3);
    frame_expect(150000, "t1_idle_frame");
    check("t1_idle_busy", 32'(busy_out), 0);

    // T2: slew up to 160000, settle for five frames, then a single done pulse
    base = done_seen;
    accept(160000, "t2_acc");
    check("t2_acc_dc", 32'(dc_out), 150000);
    check("t2_acc_ready", 32'(target_ready_out), 0);
    check("t2_acc_busy", 32'(busy_out), 1);
    check("t2_acc_limit", 32'(at_limit_out), 0);
    idle(GAP);
    for (int k = 1; k <= 5; k++) begin
      frame_expect(32'(150000 + 2000 * k), "t2_step");
      idle(GAP);
      check("t2_step_hold", 32'(dc_out), 32'(150000 + 2000 * k));
    end
    check("t2_settle_ready", 32'(target_ready_out), 1);
    check("t2_settle_busy", 32'(busy_out), 1);
    for (int k = 6; k <= 9; k++) begin
      frame_expect(160000, "t2_settle");
      check("t2_settle_done", 32'(done_out), 0);
      idle(GAP);
    end
    frame_expect(160000, "t2_f10");
    check("t2_f10_done", 32'(done_out), 1);
    check("t2_f10_busy", 32'(busy_out), 0);
    check("t2_f10_ready", 32'(target_ready_out), 1);
    tick();
    check("t2_done_fall", 32'(done_out), 0);
    check("t2_done_count", 32'(done_seen - base), 1);

    // T3: downward slew that ends on a step smaller than MAX_STEP
    do_reset();
    accept(145500, "t3_acc");
    idle(3);
    frame_expect(148000, "t3_f1");
    idle(3);
    frame_expect(146000, "t3_f2");
    idle(3);
    frame_expect(145500, "t3_f3");
    check("t3_ready", 32'(target_ready_out), 1);
    check("t3_busy", 32'(busy_out), 1);
    check("t3_limit", 32'(at_limit_out), 0);

    // T4: clamping at both ends; the last step of exactly MAX_STEP lands on the target
    do_reset();
    accept(201000, "t4_hi");
    check("t4_hi_limit", 32'(at_limit_out), 1);
    for (int k = 1; k <= 25; k++) begin
      frame_expect(32'(150000 + 2000 * k), "t4_up");
      idle(2);
    end
    check("t4_up_settle", 32'(target_ready_out), 1);
    frame_expect(200000, "t4_max_hold");
    accept(0, "t4_lo");
    check("t4_lo_limit", 32'(at_limit_out), 1);
    check("t4_lo_busy", 32'(busy_out), 1);
    for (int k = 1; k <= 50; k++) begin
      frame_expect(32'(200000 - 2000 * k), "t4_down");
      idle(2);
    end
    frame_expect(100000, "t4_min_hold");
    accept(120000, "t4_mid");
    check("t4_mid_limit", 32'(at_limit_out), 0);
    for (int k = 1; k <= 10; k++) begin
      frame_expect(32'(100000 + 2000 * k), "t4_mid_up");
      idle(2);
    end

    // T5: accept and frame in the same SETTLE cycle; the frame is ignored
    frame_expect(120000, "t5_settle1");
    base = done_seen;
    idle(2);
    frame_in        = 1'b1;
    target_valid_in = 1'b1;
    target_dc_in    = 21'd170000;
    tick();
    frame_in        = 1'b0;
    target_valid_in = 1'b0;
    check("t5_acc_dc", 32'(dc_out), 120000);
    check("t5_acc_busy", 32'(busy_out), 1);
    check("t5_acc_ready", 32'(target_ready_out), 0);
    check("t5_acc_done", 32'(done_out), 0);
    idle(GAP);
    for (int k = 1; k <= 4; k++) begin
      frame_expect(32'(120000 + 2000 * k), "t5_step");
      idle(3);
    end
    check("t5_no_done", 32'(done_seen - base), 0);

    // T6: reset during a move beats a simultaneous frame and target
    base = done_seen;
    rst_in          = 1'b1;
    frame_in        = 1'b1;
    target_valid_in = 1'b1;
    target_dc_in    = 21'd190000;
    tick();
    rst_in          = 1'b0;
    frame_in        = 1'b0;
    target_valid_in = 1'b0;
    check("t6_dc", 32'(dc_out), 150000);
    check("t6_busy", 32'(busy_out), 0);
    check("t6_ready", 32'(target_ready_out), 1);
    check("t6_limit", 32'(at_limit_out), 0);
    check("t6_done", 32'(done_out), 0);
    for (int k = 0; k < 3; k++) begin
      idle(3);
      frame_expect(150000, "t6_idle");
    end
    check("t6_no_done", 32'(done_seen - base), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
